ccff_bitstream_loader: RTL and testbench

- Upstream feeder of the configuration-chain head for a connection-block tile; default sized for an 8-mux, 6-bit-per-mux chain (48 bits).
- Accepts configuration words on a valid/ready stream and serializes them onto ccff_head.
- Produces a clock-enable for the external ICG that gates the chain's prog_clk, so upstream stalls never shift garbage into the chain.
- Counts ones returned on ccff_tail for chain-integrity checking.

---
 rtl/ccff_bitstream_loader.sv | 188 ++++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_bitstream_loader.sv
// Serializes configuration words onto a connection-block chain head and produces
// the enable for the chain's gated prog_clk; counts ones returned on the chain tail.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 48,
    parameter int WORD_W    = 32,
    parameter int CNT_W     = 16
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic              ccff_head,
    output logic              chain_clk_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  tail_ones
);

    localparam int NUM_WORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int SC_W      = $clog2(WORD_W + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] CHAIN_LEN_C = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0] NUM_WORDS_C = CNT_W'(NUM_WORDS);
    localparam logic [CNT_W-1:0] CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [SC_W-1:0]  SC_ZERO     = SC_W'(0);
    localparam logic [SC_W-1:0]  SC_ONE      = SC_W'(1);
    localparam logic [SC_W-1:0]  SC_FULL     = SC_W'(WORD_W);

    logic [1:0]        state_r,      state_s;
    logic [WORD_W-1:0] shift_r,      shift_s;
    logic [SC_W-1:0]   shift_cnt_r,  shift_cnt_s;
    logic [WORD_W-1:0] hold_r,       hold_s;
    logic              hold_valid_r, hold_valid_s;
    logic [CNT_W-1:0]  words_r,      words_s;
    logic [CNT_W-1:0]  bits_r,       bits_s;
    logic [CNT_W-1:0]  tail_ones_r,  tail_ones_s;
    logic              head_r,       head_s;
    logic              en_r,         en_s;
    logic              ready_r,      ready_s;
    logic              busy_r,       busy_s;
    logic              done_r,       done_s;
    logic              accept_s;

    assign accept_s = s_valid && ready_r;

    // Next-state: FSM, word buffering, bit emission and tail-ones counting
    always_comb begin
        state_s      = state_r;
        shift_s      = shift_r;
        shift_cnt_s  = shift_cnt_r;
        hold_s       = hold_r;
        hold_valid_s = hold_valid_r;
        words_s      = words_r;
        bits_s       = bits_r;
        tail_ones_s  = tail_ones_r;
        head_s       = head_r;
        en_s         = 1'b0;

        // The chain shifts on every cycle the registered enable is high.
        if (en_r && ccff_tail && (tail_ones_r != CNT_MAX)) begin
            tail_ones_s = tail_ones_r + CNT_ONE;
        end else begin
            tail_ones_s = tail_ones_r;
        end

        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s      = ST_LOAD;
                    words_s      = CNT_ZERO;
                    bits_s       = CNT_ZERO;
                    tail_ones_s  = CNT_ZERO;
                    shift_cnt_s  = SC_ZERO;
                    hold_valid_s = 1'b0;
                end else begin
                    state_s = state_r;
                end
            end
            ST_LOAD: begin
                if (bits_r == CHAIN_LEN_C) begin
                    // Unused upper bits of the final word are dropped here.
                    state_s      = ST_DONE;
                    shift_cnt_s  = SC_ZERO;
                    hold_valid_s = 1'b0;
                end else begin
                    if (accept_s) begin
                        words_s = words_r + CNT_ONE;
                    end else begin
                        words_s = words_r;
                    end
                    if (shift_cnt_r != SC_ZERO) begin
                        en_s   = 1'b1;
                        head_s = shift_r[0];
                        bits_s = bits_r + CNT_ONE;
                        if (shift_cnt_r == SC_ONE) begin
                            // Refill on the last bit so a stall-free stream has no bubble.
                            if (hold_valid_r) begin
                                shift_s      = hold_r;
                                shift_cnt_s  = SC_FULL;
                                hold_valid_s = 1'b0;
                            end else if (accept_s) begin
                                shift_s     = s_data;
                                shift_cnt_s = SC_FULL;
                            end else begin
                                shift_cnt_s = SC_ZERO;
                            end
                        end else begin
                            shift_s     = shift_r >> 1;
                            shift_cnt_s = shift_cnt_r - SC_ONE;
                            if (accept_s) begin
                                hold_s       = s_data;
                                hold_valid_s = 1'b1;
                            end else begin
                                hold_valid_s = hold_valid_r;
                            end
                        end
                    end else if (accept_s) begin
                        // Empty shifter: present bit 0 of the incoming word directly.
                        en_s        = 1'b1;
                        head_s      = s_data[0];
                        bits_s      = bits_r + CNT_ONE;
                        shift_s     = s_data >> 1;
                        shift_cnt_s = SC_FULL - SC_ONE;
                    end else begin
                        en_s = 1'b0;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        ready_s = (state_s == ST_LOAD) && !hold_valid_s && (words_s < NUM_WORDS_C);
        busy_s  = (state_s == ST_LOAD);
        done_s  = (state_s == ST_DONE);
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge prog_clk or negedge pReset) begin
        if (!pReset) begin
            state_r      <= ST_IDLE;
            shift_r      <= {WORD_W{1'b0}};
            shift_cnt_r  <= SC_ZERO;
            hold_r       <= {WORD_W{1'b0}};
            hold_valid_r <= 1'b0;
            words_r      <= CNT_ZERO;
            bits_r       <= CNT_ZERO;
            tail_ones_r  <= CNT_ZERO;
            head_r       <= 1'b0;
            en_r         <= 1'b0;
            ready_r      <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= state_s;
            shift_r      <= shift_s;
            shift_cnt_r  <= shift_cnt_s;
            hold_r       <= hold_s;
            hold_valid_r <= hold_valid_s;
            words_r      <= words_s;
            bits_r       <= bits_s;
            tail_ones_r  <= tail_ones_s;
            head_r       <= head_s;
            en_r         <= en_s;
            ready_r      <= ready_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
        end
    end

    assign s_ready      = ready_r;
    assign ccff_head    = head_r;
    assign chain_clk_en = en_r;
    assign busy         = busy_r;
    assign done         = done_r;
    assign tail_ones    = tail_ones_r;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Directed + randomized bench for ccff_bitstream_loader with a behavioural chain
// model; expected bit order, timing and tail counts come from plain arithmetic.
module tb_ccff_bitstream_loader;

    localparam int CL = 48;
    localparam int WW = 32;
    localparam int CW = 16;
    localparam int NW = 2;

    logic          prog_clk = 1'b0;
    logic          pReset   = 1'b0;
    logic          start    = 1'b0;
    logic          s_valid  = 1'b0;
    logic [WW-1:0] s_data   = '0;
    logic          s_ready, ccff_head, chain_clk_en, busy, done;
    logic          ccff_tail;
    logic [CW-1:0] tail_ones;
    logic [CL-1:0] chain;

    logic       sm_start = 1'b0;
    logic       sm_valid = 1'b0;
    logic [3:0] sm_data  = '0;
    logic       sm_tail  = 1'b0;
    logic       sm_ready, sm_head, sm_en, sm_busy, sm_done;
    logic [3:0] sm_tail_ones;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [WW-1:0] words_t [NW];
    int            gaps_t  [NW];
    int            hs_cyc  [NW];
    int            done_cyc;
    logic [CL-1:0] prev_chain = '0;

    logic got_head [$];
    logic got_tail [$];
    int   got_cyc  [$];
    logic sm_bits  [$];
    int   sm_cyc   [$];

    ccff_bitstream_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CNT_W(CW)) dut (
        .prog_clk(prog_clk), .pReset(pReset), .start(start), .s_valid(s_valid),
        .s_ready(s_ready), .s_data(s_data), .ccff_head(ccff_head),
        .chain_clk_en(chain_clk_en), .ccff_tail(ccff_tail), .busy(busy),
        .done(done), .tail_ones(tail_ones)
    );

    ccff_bitstream_loader #(.CHAIN_LEN(5), .WORD_W(4), .CNT_W(4)) dut_small (
        .prog_clk(prog_clk), .pReset(pReset), .start(sm_start), .s_valid(sm_valid),
        .s_ready(sm_ready), .s_data(sm_data), .ccff_head(sm_head),
        .chain_clk_en(sm_en), .ccff_tail(sm_tail), .busy(sm_busy),
        .done(sm_done), .tail_ones(sm_tail_ones)
    );

    always #5 prog_clk = ~prog_clk;

    // Downstream configuration chain: shifts toward index 0, the tail-most flop
    always @(posedge prog_clk or negedge pReset) begin
        if (!pReset) chain <= '0;
        else if (chain_clk_en) chain <= {ccff_head, chain[CL-1:1]};
    end
    assign ccff_tail = chain[0];

    // Cycle counter
    always @(posedge prog_clk) cyc <= cyc + 1;

    // Record every enabled shift cycle of both instances
    always @(negedge prog_clk) begin
        if (chain_clk_en === 1'b1) begin
            got_head.push_back(ccff_head);
            got_tail.push_back(ccff_tail);
            got_cyc.push_back(cyc);
        end
        if (sm_en === 1'b1) begin
            sm_bits.push_back(sm_head);
            sm_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input int i);
        int t;
        bit ok;
        s_valid = 1'b1;
        s_data  = words_t[i];
        ok = 1'b0;
        t  = 0;
        while (!ok && t < 200) begin
            @(negedge prog_clk);
            if (s_ready === 1'b1) begin
                hs_cyc[i] = cyc;
                ok = 1'b1;
            end
            t++;
        end
        @(posedge prog_clk);
        #1;
        s_valid = 1'b0;
        chk("handshake", 64'(ok), 64'd1);
    endtask

    task automatic do_load(input bit mid_start);
        int t;
        got_head.delete(); got_tail.delete(); got_cyc.delete();
        @(posedge prog_clk); #1 start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
        for (int i = 0; i < NW; i++) begin
            repeat (gaps_t[i]) @(posedge prog_clk);
            #1;
            send_word(i);
            if (mid_start && i == 0) begin
                start = 1'b1;
                @(posedge prog_clk); #1 start = 1'b0;
            end
        end
        if (mid_start) begin
            s_valid = 1'b1;
            s_data  = $urandom();
            for (int j = 0; j < 3; j++) begin
                @(negedge prog_clk);
                chk("ready_after_w", 64'(s_ready), 64'd0);
            end
            s_valid = 1'b0;
        end
        t = 0;
        while (done !== 1'b1 && t < 400) begin
            @(negedge prog_clk);
            t++;
        end
        done_cyc = cyc;
        chk("done_seen", 64'(done), 64'd1);
    endtask

    task automatic check_load(input string tag);
        logic [CL-1:0] exp_v;
        int mis_h, mis_t, mis_c, e, prev;
        for (int k = 0; k < CL; k++) exp_v[k] = words_t[k / WW][k % WW];
        chk({tag, ".en_count"}, 64'(got_head.size()), 64'(CL));
        mis_h = 0; mis_t = 0; mis_c = 0; prev = -1000;
        for (int k = 0; k < CL; k++) begin
            e = hs_cyc[k / WW] + 1;
            if (e < prev + 1) e = prev + 1;
            prev = e;
            if (k < got_head.size()) begin
                if (got_head[k] !== exp_v[k])      mis_h++;
                if (got_tail[k] !== prev_chain[k]) mis_t++;
                if (got_cyc[k] != e)               mis_c++;
            end
        end
        chk({tag, ".head_order"}, 64'(mis_h), 64'd0);
        chk({tag, ".tail_stream"}, 64'(mis_t), 64'd0);
        chk({tag, ".en_timing"}, 64'(mis_c), 64'd0);
        if (got_cyc.size() > 0) chk({tag, ".done_latency"}, 64'(done_cyc), 64'(got_cyc[$] + 1));
        chk({tag, ".tail_ones"}, 64'(tail_ones), 64'($countones(prev_chain)));
        chk({tag, ".chain"}, 64'(chain), 64'(exp_v));
        chk({tag, ".busy"}, 64'(busy), 64'd0);
        prev_chain = exp_v;
    endtask

    initial begin
        int t;
        logic [3:0] sw [2];
        logic [4:0] got5;

        #12;
        chk("reset_outputs", 64'({s_ready, ccff_head, chain_clk_en, busy, done, tail_ones}), 64'd0);
        #10 pReset = 1'b1;

        words_t[0] = 32'hA5A5_0F0F; words_t[1] = 32'h0000_1234;
        gaps_t[0] = 0; gaps_t[1] = 0;
        do_load(1'b0);
        check_load("first");

        gaps_t[1] = 5;
        do_load(1'b0);
        check_load("stall5");

        words_t[0] = 32'h0; words_t[1] = 32'h0;
        gaps_t[1] = 40;
        do_load(1'b0);
        check_load("zeros_gap40");

        words_t[0] = $urandom(); words_t[1] = $urandom();
        gaps_t[0] = $urandom_range(0, 3); gaps_t[1] = $urandom_range(0, 10);
        do_load(1'b0);
        check_load("rand_prefill");

        words_t[0] = $urandom(); words_t[1] = $urandom();
        gaps_t[0] = 0; gaps_t[1] = $urandom_range(0, 5);
        do_load(1'b1);
        check_load("mid_start");

        for (int n = 0; n < 4; n++) begin
            words_t[0] = $urandom(); words_t[1] = $urandom();
            gaps_t[0] = $urandom_range(0, 40); gaps_t[1] = $urandom_range(0, 40);
            do_load(1'b0);
            check_load("random");
        end

        // Abandon a load after 20 bits
        got_head.delete(); got_tail.delete(); got_cyc.delete();
        words_t[0] = $urandom(); words_t[1] = $urandom();
        @(posedge prog_clk); #1 start = 1'b1;
        @(posedge prog_clk); #1 start = 1'b0;
        send_word(0);
        t = 0;
        while (got_head.size() < 20 && t < 200) begin
            @(negedge prog_clk);
            t++;
        end
        chk("reached_20_bits", 64'(got_head.size() >= 20), 64'd1);
        @(posedge prog_clk); #2 pReset = 1'b0;
        #1;
        chk("midload_reset_outputs", 64'({s_ready, ccff_head, chain_clk_en, busy, done, tail_ones}), 64'd0);
        #10 pReset = 1'b1;
        prev_chain = '0;
        words_t[0] = $urandom(); words_t[1] = $urandom();
        gaps_t[0] = 0; gaps_t[1] = $urandom_range(0, 8);
        do_load(1'b0);
        check_load("after_reset");

        // Short chain: two 4-bit words, only bit 0 of the second is used
        sw[0] = 4'($urandom_range(0, 15)); sw[1] = 4'($urandom_range(0, 15));
        sm_bits.delete(); sm_cyc.delete();
        @(posedge prog_clk); #1 sm_start = 1'b1;
        @(posedge prog_clk); #1 sm_start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            bit ok;
            sm_valid = 1'b1; sm_data = sw[i]; ok = 1'b0; t = 0;
            while (!ok && t < 100) begin
                @(negedge prog_clk);
                if (sm_ready === 1'b1) ok = 1'b1;
                t++;
            end
            @(posedge prog_clk); #1 sm_valid = 1'b0;
            chk("sm_handshake", 64'(ok), 64'd1);
        end
        sm_valid = 1'b1; sm_data = 4'hF;
        @(negedge prog_clk);
        chk("sm_ready_after_w", 64'(sm_ready), 64'd0);
        sm_valid = 1'b0;
        t = 0;
        while (sm_done !== 1'b1 && t < 100) begin
            @(negedge prog_clk);
            t++;
        end
        chk("sm_done", 64'(sm_done), 64'd1);
        chk("sm_en_count", 64'(sm_bits.size()), 64'd5);
        got5 = 5'd0;
        for (int k = 0; k < 5; k++) if (k < sm_bits.size()) got5[k] = sm_bits[k];
        chk("sm_bits", 64'(got5), 64'({sw[1][0], sw[0]}));
        if (sm_cyc.size() == 5) chk("sm_consecutive", 64'(sm_cyc[4] - sm_cyc[0]), 64'd4);
        chk("sm_tail_ones", 64'(sm_tail_ones), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
